// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic/compare ops and iterative
// multi-cycle shifts, with valid/ready handshakes on both sides.

package alu_exec_pkg;
  typedef logic [3:0] alu_command_t;
  localparam alu_command_t ALU_NONE = 4'd0;
  localparam alu_command_t ALU_ADD  = 4'd1;
  localparam alu_command_t ALU_SUB  = 4'd2;
  localparam alu_command_t ALU_AND  = 4'd3;
  localparam alu_command_t ALU_OR   = 4'd4;
  localparam alu_command_t ALU_XOR  = 4'd5;
  localparam alu_command_t ALU_SLT  = 4'd6;
  localparam alu_command_t ALU_SLTU = 4'd7;
  localparam alu_command_t ALU_SLL  = 4'd8;
  localparam alu_command_t ALU_SRL  = 4'd9;
  localparam alu_command_t ALU_SRA  = 4'd10;
endpackage

module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int IMM_W      = 12,
  parameter int SHIFT_STEP = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  alu_command_t       alu_op,
  input  logic [XLEN-1:0]    operand_a,
  input  logic [XLEN-1:0]    operand_b,
  input  logic [IMM_W-1:0]   immediate,
  input  logic               b_is_immediate,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    alu_result,
  output logic               illegal_op,
  output logic [1:0]         dbg_state
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [SHW:0] STEP = (SHW+1)'(SHIFT_STEP);
  localparam logic [31:0] ILLEGAL_WORD = 32'hdeadbeef;

  logic [1:0]      r_state;
  logic            r_out_valid;
  logic [XLEN-1:0] r_result;
  logic            r_illegal;
  logic [XLEN-1:0] r_sh_val;
  logic [SHW:0]    r_sh_rem;
  alu_command_t    r_sh_op;

  logic            w_ready;
  logic            w_accept;
  logic [XLEN-1:0] w_b;
  logic [SHW-1:0]  w_shamt;
  logic            w_is_shift;
  logic [XLEN-1:0] w_result;
  logic            w_illegal;
  logic [SHW:0]    w_step;
  logic [SHW:0]    w_rem_next;
  logic [XLEN-1:0] w_sh_next;

  // Handshake: a transfer happens on any rising edge where valid and ready are
  // both high; valid never waits on ready, and the output side holds
  // alu_result/illegal_op stable while out_valid is high and out_ready is low.
  assign w_ready  = !reset && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && w_ready;

  assign w_b        = b_is_immediate ? XLEN'($signed(immediate)) : operand_b;
  assign w_shamt    = w_b[SHW-1:0];
  assign w_is_shift = (alu_op == ALU_SLL) || (alu_op == ALU_SRL) || (alu_op == ALU_SRA);

  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (alu_op)
      ALU_NONE: w_result = '0;
      ALU_ADD:  w_result = operand_a + w_b;
      ALU_SUB:  w_result = operand_a - w_b;
      ALU_AND:  w_result = operand_a & w_b;
      ALU_OR:   w_result = operand_a | w_b;
      ALU_XOR:  w_result = operand_a ^ w_b;
      ALU_SLT:  w_result = XLEN'($signed(operand_a) < $signed(w_b));
      ALU_SLTU: w_result = XLEN'(operand_a < w_b);
      // Only reached with a zero shift amount; nonzero amounts go to SHIFT.
      ALU_SLL, ALU_SRL, ALU_SRA: w_result = operand_a;
      default: begin
        w_result  = XLEN'(ILLEGAL_WORD);
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_step     = (r_sh_rem > STEP) ? STEP : r_sh_rem;
  assign w_rem_next = r_sh_rem - w_step;

  always_comb begin
    w_sh_next = r_sh_val;
    case (r_sh_op)
      ALU_SLL: w_sh_next = r_sh_val << w_step;
      ALU_SRL: w_sh_next = r_sh_val >> w_step;
      ALU_SRA: w_sh_next = XLEN'($signed(r_sh_val) >>> w_step);
      default: w_sh_next = r_sh_val;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_illegal   <= 1'b0;
      r_sh_val    <= '0;
      r_sh_rem    <= '0;
      r_sh_op     <= ALU_NONE;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && (alu_op != ALU_NONE)) begin
            if (w_is_shift && (w_shamt != '0)) begin
              r_state  <= ST_SHIFT;
              r_sh_val <= operand_a;
              r_sh_rem <= {1'b0, w_shamt};
              r_sh_op  <= alu_op;
            end else begin
              r_result    <= w_result;
              r_illegal   <= w_illegal;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          r_sh_val <= w_sh_next;
          r_sh_rem <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state     <= ST_IDLE;
            r_result    <= w_sh_next;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = w_ready;
  assign out_valid  = r_out_valid;
  assign alu_result = r_result;
  assign illegal_op = r_illegal;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed scenarios plus randomized traffic checked
// against an arithmetic reference model through an expected-result queue.

module tb_alu_exec_unit;
  import alu_exec_pkg::*;

  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_valid8;
  logic              in_ready, in_ready8;
  alu_command_t      alu_op;
  logic [XLEN-1:0]   operand_a, operand_b;
  logic [11:0]       immediate;
  logic              b_is_immediate;
  logic              out_valid, out_valid8;
  logic              out_ready;
  logic              out_ready8 = 1'b1;
  logic [XLEN-1:0]   alu_result, alu_result8;
  logic              illegal_op, illegal_op8;
  logic [1:0]        dbg_state, dbg_state8;

  logic [XLEN:0]     exp_q[$];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                n_results = 0;
  logic              rand_done;

  alu_exec_unit #(.XLEN(XLEN), .IMM_W(12), .SHIFT_STEP(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .operand_a(operand_a), .operand_b(operand_b),
    .immediate(immediate), .b_is_immediate(b_is_immediate),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .illegal_op(illegal_op), .dbg_state(dbg_state)
  );

  alu_exec_unit #(.XLEN(XLEN), .IMM_W(12), .SHIFT_STEP(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .alu_op(alu_op), .operand_a(operand_a), .operand_b(operand_b),
    .immediate(immediate), .b_is_immediate(b_is_immediate),
    .out_valid(out_valid8), .out_ready(out_ready8), .alu_result(alu_result8),
    .illegal_op(illegal_op8), .dbg_state(dbg_state8)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] b_eff(input logic bimm, input logic [11:0] imm,
                                            input logic [XLEN-1:0] opb);
    return bimm ? {{20{imm[11]}}, imm} : opb;
  endfunction

  function automatic logic [XLEN:0] model(input alu_command_t op, input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      ALU_ADD:  return {1'b0, a + b};
      ALU_SUB:  return {1'b0, a - b};
      ALU_AND:  return {1'b0, a & b};
      ALU_OR:   return {1'b0, a | b};
      ALU_XOR:  return {1'b0, a ^ b};
      ALU_SLT:  return {1'b0, 31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: return {1'b0, 31'd0, (a < b)};
      ALU_SLL:  return {1'b0, a << sh};
      ALU_SRL:  return {1'b0, a >> sh};
      ALU_SRA:  return {1'b0, 32'($signed(a) >>> sh)};
      default:  return {1'b1, 32'hdeadbeef};
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic scoreboard();
    logic [XLEN:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          n_results++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got illegal=%0b result=%h, no result expected", illegal_op, alu_result);
          end else begin
            e = exp_q.pop_front();
            if ({illegal_op, alu_result} !== e) begin
              n_fail++;
              $display("FAIL sb_result: got illegal=%0b result=%h, expected illegal=%0b result=%h",
                       illegal_op, alu_result, e[XLEN], e[XLEN-1:0]);
            end
          end
        end
        if (in_valid && in_ready && (alu_op != ALU_NONE))
          exp_q.push_back(model(alu_op, operand_a, b_eff(b_is_immediate, immediate, operand_b)));
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input alu_command_t op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [11:0] imm, input logic bimm);
    int n;
    alu_op = op; operand_a = a; operand_b = b; immediate = imm; b_is_immediate = bimm;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic bp_toggle();
    while (!rand_done) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int bad;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, illegal_op, alu_result} !== {3'b000, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%0b vld=%0b ill=%0b res=%h, required 0 0 0 0",
               in_ready, out_valid, illegal_op, alu_result);
    end
    reset = 1'b0; #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %0b required 1", in_ready);
    end
    send(ALU_ADD, 32'd3, 32'd4, 12'd0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || alu_result !== 32'd7) begin
      n_fail++; $display("FAIL reset_pre_add: got vld=%0b res=%h required 1 00000007", out_valid, alu_result);
    end
    send(ALU_SRA, $urandom, 32'd20, 12'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1; #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_midshift_pre: got rdy=%0b vld=%0b required 0 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid, illegal_op, alu_result} !== {3'b000, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_midshift: got rdy=%0b vld=%0b ill=%0b res=%h, required 0 0 0 0",
               in_ready, out_valid, illegal_op, alu_result);
    end
    @(posedge clk); #1;
    reset = 1'b0; #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_midshift_release: in_ready got %0b required 1", in_ready);
    end
    bad = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL reset_abort: out_valid high %0d cycles after abort, required 0", bad);
    end
  endtask

  task automatic test_add_sub();
    send(ALU_ADD, 32'hFFFFFFFF, 32'h12345678, 12'h001, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || alu_result !== 32'h0) begin
      n_fail++; $display("FAIL add_wrap: got vld=%0b res=%h required 1 00000000", out_valid, alu_result);
    end
    send(ALU_SUB, 32'd5, 32'd7, 12'h7FF, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || alu_result !== 32'hFFFFFFFE) begin
      n_fail++; $display("FAIL sub_neg: got vld=%0b res=%h required 1 fffffffe", out_valid, alu_result);
    end
  endtask

  task automatic test_compare();
    send(ALU_SLT, 32'h80000000, 32'd1, 12'd0, 1'b0);
    n_checks++;
    if (alu_result !== 32'd1) begin
      n_fail++; $display("FAIL slt_signed: got %h required 00000001", alu_result);
    end
    send(ALU_SLTU, 32'h80000000, 32'd1, 12'd0, 1'b0);
    n_checks++;
    if (alu_result !== 32'd0) begin
      n_fail++; $display("FAIL sltu_unsigned: got %h required 00000000", alu_result);
    end
    send(ALU_ADD, 32'd10, 32'd0, 12'hFFF, 1'b1);
    n_checks++;
    if (alu_result !== 32'd9) begin
      n_fail++; $display("FAIL add_imm_sext: got %h required 00000009", alu_result);
    end
  endtask

  task automatic test_shift();
    int cyc, bad, lat1, lat8, sh;
    logic [XLEN-1:0] r1, r8;
    logic [XLEN:0] e;
    out_ready = 1'b1;
    send(ALU_SRA, 32'h80000000, 32'd31, 12'd0, 1'b0);
    cyc = 1; bad = 0;
    while (!out_valid && cyc < 100) begin
      if (in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (cyc != 32 || bad != 0 || alu_result !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL sra31_step1: got latency=%0d ready_high=%0d res=%h, required 32 0 ffffffff", cyc, bad, alu_result);
    end
    @(posedge clk); #1;
    alu_op = ALU_SRA; operand_a = 32'h80000000; operand_b = 32'd31; b_is_immediate = 1'b0;
    in_valid8 = 1'b1; #1;
    n_checks++;
    if (in_ready8 !== 1'b1) begin
      n_fail++; $display("FAIL step8_ready: got %0b required 1", in_ready8);
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    cyc = 1;
    while (!out_valid8 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (cyc != 5 || alu_result8 !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL sra31_step8: got latency=%0d res=%h, required 5 ffffffff", cyc, alu_result8);
    end
    repeat (10) begin
      @(posedge clk); #1;
      alu_op = alu_command_t'(4'd8 + 4'($urandom_range(0, 2)));
      operand_a = $urandom; operand_b = $urandom; b_is_immediate = 1'b0;
      in_valid = 1'b1; in_valid8 = 1'b1; #1;
      n_checks++;
      if (in_ready !== 1'b1 || in_ready8 !== 1'b1) begin
        n_fail++; $display("FAIL shift_idle_ready: got %0b %0b required 1 1", in_ready, in_ready8);
      end
      e = model(alu_op, operand_a, operand_b);
      sh = int'(operand_b[4:0]);
      @(posedge clk); #1;
      in_valid = 1'b0; in_valid8 = 1'b0;
      lat1 = 0; lat8 = 0; r1 = '0; r8 = '0;
      for (int c = 1; c <= 40; c++) begin
        if (out_valid && lat1 == 0) begin lat1 = c; r1 = alu_result; end
        if (out_valid8 && lat8 == 0) begin lat8 = c; r8 = alu_result8; end
        @(posedge clk); #1;
      end
      n_checks++;
      if (lat1 != ((sh == 0) ? 1 : sh + 1) || r1 !== e[XLEN-1:0]) begin
        n_fail++;
        $display("FAIL shift_rand_step1: shamt=%0d got latency=%0d res=%h, required %0d %h",
                 sh, lat1, r1, (sh == 0) ? 1 : sh + 1, e[XLEN-1:0]);
      end
      n_checks++;
      if (lat8 != ((sh == 0) ? 1 : (sh + 7) / 8 + 1) || r8 !== e[XLEN-1:0]) begin
        n_fail++;
        $display("FAIL shift_rand_step8: shamt=%0d got latency=%0d res=%h, required %0d %h",
                 sh, lat8, r8, (sh == 0) ? 1 : (sh + 7) / 8 + 1, e[XLEN-1:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [XLEN-1:0] a, b, c, d;
    int bad;
    a = $urandom; b = $urandom; c = $urandom; d = $urandom;
    out_ready = 1'b1;
    send(ALU_XOR, a, b, 12'd0, 1'b0);
    out_ready = 1'b0;
    alu_op = ALU_ADD; operand_a = c; operand_b = d; b_is_immediate = 1'b0;
    in_valid = 1'b1; #1;
    bad = 0;
    repeat (3) begin
      if (out_valid !== 1'b1 || alu_result !== (a ^ b) || illegal_op !== 1'b0 || in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL bp_hold: %0d stalled cycles wrong (res=%h rdy=%0b), required 0", bad, alu_result, in_ready);
    end
    out_ready = 1'b1; #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready: got %0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || alu_result !== (c + d)) begin
      n_fail++; $display("FAIL bp_no_gap: got vld=%0b res=%h required 1 %h", out_valid, alu_result, c + d);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_drop: out_valid got %0b required 0", out_valid);
    end
  endtask

  task automatic test_none_illegal();
    int n0;
    out_ready = 1'b1;
    n0 = n_results;
    send(ALU_ADD, 32'd100, 32'd23, 12'd0, 1'b0);
    send(ALU_NONE, 32'd1, 32'd1, 12'd0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL none_bubble: out_valid got %0b required 0", out_valid);
    end
    send(ALU_ADD, 32'd7, 32'd0, 12'h005, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (n_results - n0 != 2) begin
      n_fail++; $display("FAIL none_count: got %0d results required 2", n_results - n0);
    end
    send(alu_command_t'(4'hF), $urandom, $urandom, 12'd0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || illegal_op !== 1'b1 || alu_result !== 32'hdeadbeef) begin
      n_fail++; $display("FAIL illegal_op: got vld=%0b ill=%0b res=%h required 1 1 deadbeef",
                         out_valid, illegal_op, alu_result);
    end
    send(ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 12'd0, 1'b0);
    n_checks++;
    if (illegal_op !== 1'b0 || alu_result !== 32'h00F000F0) begin
      n_fail++; $display("FAIL illegal_clear: got ill=%0b res=%h required 0 00f000f0", illegal_op, alu_result);
    end
  endtask

  task automatic test_random();
    int n;
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          send(alu_command_t'(4'($urandom_range(0, 12))), $urandom, $urandom,
               12'($urandom), 1'($urandom_range(0, 1)));
        end
        rand_done = 1'b1;
      end
      bp_toggle();
    join
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL random_drain: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; in_valid8 = 1'b0; out_ready = 1'b1;
    alu_op = ALU_NONE; operand_a = '0; operand_b = '0; immediate = '0; b_is_immediate = 1'b0;
    rand_done = 1'b0;
    fork
      scoreboard();
    join_none
    test_reset();
    test_add_sub();
    test_compare();
    test_shift();
    test_backpressure();
    test_none_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
